// File: rtl/main_memory_burst_controller.sv
// Line-burst main memory below the last-level cache: one request at a time, read wins
// over write, fixed access latency, per-beat write handshake and line range checking.
module main_memory_burst_controller #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int NUM_WORDS      = 1024,
  parameter int BURST_LEN      = 4,
  parameter int ACCESS_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_read_request,
  input  logic                  mem_write_request,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_write_data_valid,
  output logic                  mem_write_data_ready,
  output logic                  mem_request_accept,
  output logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_read_data_valid,
  output logic                  mem_ready,
  output logic                  mem_busy,
  output logic                  mem_error
);
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int LAT_W  = $clog2(ACCESS_LATENCY + 1);
  localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(BURST_LEN - 1);
  localparam longint unsigned       MAX_BASE  = longint'(NUM_WORDS - BURST_LEN);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [LAT_W-1:0]      LAT_INIT  = LAT_W'(ACCESS_LATENCY);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_WRITE, S_DONE} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic                    is_read_q;
  logic [BEAT_W-1:0]       beat_q;
  logic [LAT_W-1:0]        lat_q;
  logic                    accept_q, rvalid_q, wready_q, done_q, busy_q, error_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic [DATA_WIDTH-1:0]   mem [NUM_WORDS];

  logic [ADDR_WIDTH-1:0]   line_base_d;
  logic                    out_of_range_d;
  logic [BEAT_W-1:0]       rd_beat_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_d;
  logic                    wr_fire_d;

  // Range check widened to 64 bits so base + BURST_LEN can never wrap.
  always_comb begin
    line_base_d    = mem_address & LINE_MASK;
    out_of_range_d = 64'(line_base_d) > MAX_BASE;
    rd_beat_d      = (state_q == S_READ) ? beat_q + BEAT_W'(1) : '0;
    rd_addr_d      = base_q + ADDR_WIDTH'(rd_beat_d);
    wr_addr_d      = base_q + ADDR_WIDTH'(beat_q);
    wr_fire_d      = (state_q == S_WRITE) && wready_q && mem_write_data_valid;
  end

  // Array is deliberately unreset so contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (wr_fire_d) mem[wr_addr_d[IDX_W-1:0]] <= mem_write_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      is_read_q <= 1'b0;
      beat_q    <= '0;
      lat_q     <= '0;
      accept_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      wready_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      accept_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mem_read_request || mem_write_request) begin
            if (out_of_range_d) begin
              error_q <= 1'b1;
            end else begin
              base_q    <= line_base_d;
              is_read_q <= mem_read_request;
              lat_q     <= LAT_INIT;
              beat_q    <= '0;
              accept_q  <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (lat_q == LAT_W'(1)) begin
            beat_q <= '0;
            if (is_read_q) begin
              state_q  <= S_READ;
              rvalid_q <= 1'b1;
              rdata_q  <= mem[rd_addr_d[IDX_W-1:0]];
            end else begin
              state_q  <= S_WRITE;
              wready_q <= 1'b1;
            end
          end else begin
            lat_q <= lat_q - LAT_W'(1);
          end
        end
        S_READ: begin
          if (beat_q == LAST_BEAT) begin
            state_q  <= S_DONE;
            rvalid_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            beat_q  <= beat_q + BEAT_W'(1);
            rdata_q <= mem[rd_addr_d[IDX_W-1:0]];
          end
        end
        S_WRITE: begin
          if (wr_fire_d) begin
            if (beat_q == LAST_BEAT) begin
              state_q  <= S_DONE;
              wready_q <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_write_data_ready = wready_q;
  assign mem_request_accept   = accept_q;
  assign mem_read_data        = rdata_q;
  assign mem_read_data_valid  = rvalid_q;
  assign mem_ready            = done_q;
  assign mem_busy             = busy_q;
  assign mem_error            = error_q;

endmodule

// File: doc/main_memory_burst_controller.md
Name: main_memory_burst_controller

Overview:
- Parametrised successor to the single-word main memory controller. It sits below the last-level cache and services whole-line read and write bursts.
- Adds configurable data width, depth, burst length and access latency, plus a per-beat write-data handshake and address-range checking.
- One request at a time; read has priority over write.

Parameters:
- DATA_WIDTH, 32, bits per memory word / beat
- ADDR_WIDTH, 16, word-address width
- NUM_WORDS, 1024, memory depth in words; must be a multiple of BURST_LEN
- BURST_LEN, 4, words per line; power of two, at least 1
- ACCESS_LATENCY, 3, wait cycles between accept and the first beat; at least 1

Ports:
- clk  input  1  clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- mem_read_request  input  1  level request for a line read
- mem_write_request  input  1  level request for a line write
- mem_address  input  ADDR_WIDTH  word address; low log2(BURST_LEN) bits ignored
- mem_write_data  input  DATA_WIDTH  write beat data
- mem_write_data_valid  input  1  write beat present
- mem_write_data_ready  output  1  controller accepts a write beat this cycle
- mem_request_accept  output  1  one-cycle pulse: request captured
- mem_read_data  output  DATA_WIDTH  read beat data
- mem_read_data_valid  output  1  read beat valid; no backpressure
- mem_ready  output  1  one-cycle pulse: transaction complete
- mem_busy  output  1  high whenever the FSM is not in IDLE
- mem_error  output  1  one-cycle pulse: out-of-range request rejected

Behaviour:
- Clocking and reset
  - Clock is clk. Reset is reset_n: asynchronous assertion, active-low.
  - All outputs are registered.
- Reset values
  - All outputs are 0, including mem_read_data.
  - FSM goes to IDLE; beat and latency counters are 0.
  - The memory array is not reset. Contents are undefined at power-up and retained across reset.
- FSM states: IDLE, WAIT, READ_BURST, WRITE_BURST, DONE.
- IDLE
  - Requests are sampled only in IDLE.
  - Line base = mem_address with its low log2(BURST_LEN) bits forced to 0.
  - If line base + BURST_LEN > NUM_WORDS: pulse mem_error for one cycle, stay in IDLE, no memory access.
  - Otherwise: latch the base address and the direction (read if mem_read_request, else write), load the latency counter, go to WAIT. mem_request_accept is high for that first WAIT cycle only.
  - Read and write requests asserted together: read wins. A write request still held is serviced after the controller returns to IDLE.
- WAIT: lasts exactly ACCESS_LATENCY cycles, then goes to READ_BURST or WRITE_BURST.
- READ_BURST
  - Lasts exactly BURST_LEN consecutive cycles.
  - Each cycle: mem_read_data_valid = 1 and mem_read_data = memory[base + beat], beat counting 0 to BURST_LEN-1.
  - Then go to DONE.
- WRITE_BURST
  - mem_write_data_ready = 1 throughout.
  - On a cycle with mem_write_data_valid && mem_write_data_ready, write memory[base + beat] and increment beat.
  - Valid low stalls the burst with no timeout.
  - After the beat BURST_LEN-1 write, ready drops the next cycle and the FSM goes to DONE.
- DONE
  - mem_ready = 1 for one cycle, then IDLE.
  - Earliest next accept is one cycle after DONE.
- Timing
  - Request sampled at edge 0: accept in cycle 1, first read beat in cycle ACCESS_LATENCY+1, mem_ready in cycle ACCESS_LATENCY+BURST_LEN+1.
  - Read of a line written in an earlier transaction returns the new data.
- Requester contract
  - Deassert the request after seeing accept.
  - A request still high in IDLE starts a new transaction.
- Outputs when not asserted
  - mem_read_data holds its last value when valid is low.
  - mem_error, mem_ready and mem_request_accept are never high at the same time.
- Reset mid-operation
  - Abort immediately and return to IDLE with all outputs 0.
  - Write beats already committed stay in memory; the remaining beats are not written.
- Widths
  - Beat counter is log2(BURST_LEN) bits (minimum 1).
  - Latency counter is wide enough to hold ACCESS_LATENCY.
  - Address arithmetic is ADDR_WIDTH bits; the range check is computed without overflow.

Test Plan:
- Defaults; write line 0x0010 with beats 0xA0..0xA3, valid held high, then read 0x0010 -> accept in cycle 1, read valid cycles 4-7 with 0xA0,0xA1,0xA2,0xA3, mem_ready in cycle 8, busy cycles 1-8.
- Read mem_address 0x0013 after the above -> identical beats 0xA0..0xA3 (alignment masking).
- Read 0x0400 (NUM_WORDS) -> mem_error pulse for one cycle, no accept, busy stays 0; read 0x03FC -> normal completion.
- Read and write held together at 0x0020 -> read burst first, then mem_ready, then write accepted after IDLE.
- Write burst with valid pattern 1,0,0,1,1,0,1 -> exactly 4 words committed, mem_ready one cycle after the 4th accepted beat, read-back matches.
- reset_n low after 2 accepted beats of a write of 0xB0..0xB3 to 0x0040 (line previously 0xC0..0xC3) -> all outputs 0 asynchronously; read-back returns 0xB0,0xB1,0xC2,0xC3.
